// File: rtl/fir_pkg.sv
// Shared types, default coefficient set and output scaling helper for the
// symmetric TDM FIR.
//   coef_t       : signed coefficient type of the default set
//   DEFAULT_COEF : half-length coefficient set loaded at reset
//   state_t      : FSM encoding (IDLE / ACC)
//   default_coef : sign-extended default coefficient, 0 beyond the table
//   round_sat    : round-half-up, arithmetic shift, clip to out_w bits
package fir_pkg;

  localparam int unsigned DEF_COEF_W = 9;
  localparam int unsigned DEF_HALF   = 10;

  typedef logic signed [DEF_COEF_W-1:0] coef_t;

  localparam coef_t DEFAULT_COEF [DEF_HALF] = '{
    9'h001, 9'h1F7, 9'h1FE, 9'h00D, 9'h00E,
    9'h1F2, 9'h1D9, 9'h1FD, 9'h063, 9'h0C1
  };

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic logic signed [63:0] default_coef(input int unsigned idx);
    logic signed [63:0] c;
    c = '0;
    if (idx < DEF_HALF) c = 64'(DEFAULT_COEF[idx[3:0]]);
    return c;
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int unsigned      shift,
                                                   input int unsigned      out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Shift-enabled sample delay line; tap 0 holds the newest sample.
//   clk, resetn : clock, async active-low reset (clears all taps)
//   shift_en_i  : shift one position and load din_i into tap 0
//   din_i       : incoming sample
//   taps_o      : packed tap array, taps_o[k] = x[k]
module fir_delay_line #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned N_TAPS = 20
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           shift_en_i,
  input  logic [DATA_W-1:0]              din_i,
  output logic [N_TAPS-1:0][DATA_W-1:0]  taps_o
);

  logic [N_TAPS-1:0][DATA_W-1:0] taps_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      taps_q <= '0;
    end else if (shift_en_i) begin
      taps_q <= {taps_q[N_TAPS-2:0], din_i};
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/fir_sym_tdm.sv
// Symmetric linear-phase FIR, one instance per I/Q rail. Taps j and
// N_TAPS-1-j are pre-added, then N_MAC multipliers sweep the half-length
// coefficient set over K = N_TAPS/(2*N_MAC) cycles per output.
//   clk, resetn          : clock, async active-low reset
//   in_valid / in_ready  : sample handshake (ready only in IDLE)
//   data_in              : signed sample
//   out_valid / data_out : one-cycle pulse with rounded, saturated result
//   coef_we/addr/wdata   : run-time coefficient write (IDLE only)
//   coef_err             : sticky, a coefficient write was dropped
module fir_sym_tdm
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned COEF_W    = 9,
  parameter int unsigned N_TAPS    = 20,
  parameter int unsigned N_MAC     = 2,
  parameter int unsigned OUT_SHIFT = 9,
  parameter int unsigned DECIM     = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             data_out,
  input  logic                          coef_we,
  input  logic [$clog2(N_TAPS/2)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]             coef_wdata,
  output logic                          coef_err
);

  localparam int unsigned HALF   = N_TAPS / 2;
  localparam int unsigned K      = HALF / N_MAC;
  localparam int unsigned AW     = $clog2(HALF);
  localparam int unsigned IDX_W  = $clog2(N_TAPS);
  localparam int unsigned PH_W   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned DC_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + 1 + $clog2(HALF);

  state_t                         state_q, state_d;
  logic [PH_W-1:0]                phase_q;
  logic [DC_W-1:0]                decim_cnt_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic signed [ACC_W-1:0]        partial;
  logic signed [ACC_W-1:0]        acc_sum;
  logic [DATA_W-1:0]              data_out_q;
  logic                           out_valid_q;
  logic                           coef_err_q;
  logic [COEF_W-1:0]              coef_q [HALF];
  logic [N_TAPS-1:0][DATA_W-1:0]  taps;

  logic [IDX_W-1:0]               tap_j [N_MAC];
  logic signed [DATA_W:0]         pre   [N_MAC];
  logic signed [PROD_W-1:0]       prod  [N_MAC];

  logic accept, start, last_phase, addr_ok, coef_wr;

  assign accept     = in_valid && in_ready;
  assign start      = accept && (32'(decim_cnt_q) == DECIM - 1);
  assign last_phase = (32'(phase_q) == K - 1);
  assign addr_ok    = (32'(coef_addr) < HALF);
  assign coef_wr    = coef_we && (state_q == IDLE) && addr_ok;

  fir_delay_line #(
    .DATA_W (DATA_W),
    .N_TAPS (N_TAPS)
  ) u_dly (
    .clk        (clk),
    .resetn     (resetn),
    .shift_en_i (accept),
    .din_i      (data_in),
    .taps_o     (taps)
  );

  // Folded MAC lanes: lane m covers coefficient phase*N_MAC+m.
  always_comb begin
    partial = '0;
    tap_j   = '{default: '0};
    pre     = '{default: '0};
    prod    = '{default: '0};
    for (int unsigned m = 0; m < N_MAC; m++) begin
      tap_j[m] = IDX_W'(32'(phase_q) * N_MAC + m);
      pre[m]   = (DATA_W+1)'(signed'(taps[tap_j[m]]))
               + (DATA_W+1)'(signed'(taps[IDX_W'(N_TAPS - 1) - tap_j[m]]));
      prod[m]  = PROD_W'(signed'(coef_q[AW'(tap_j[m])])) * PROD_W'(pre[m]);
      partial  = partial + ACC_W'(prod[m]);
    end
  end

  assign acc_sum = acc_q + partial;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = ACC;
      ACC:     if (last_phase) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = out_valid_q;
    data_out  = data_out_q;
    coef_err  = coef_err_q;
  end

  // The final phase folds its partial sum straight into the output stage,
  // so the result registers at the K-th edge after the accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q     <= '0;
      decim_cnt_q <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        decim_cnt_q <= (32'(decim_cnt_q) == DECIM - 1) ? '0 : decim_cnt_q + DC_W'(1);
      end
      if (state_q == IDLE) begin
        if (start) begin
          acc_q   <= '0;
          phase_q <= '0;
        end
      end else if (last_phase) begin
        data_out_q  <= DATA_W'(round_sat(64'(acc_sum), OUT_SHIFT, DATA_W));
        out_valid_q <= 1'b1;
      end else begin
        acc_q   <= acc_sum;
        phase_q <= phase_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < HALF; i++) begin
        coef_q[AW'(i)] <= COEF_W'(default_coef(i));
      end
      coef_err_q <= 1'b0;
    end else begin
      if (coef_wr) coef_q[coef_addr] <= coef_wdata;
      if (coef_we && !coef_wr) coef_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sym_tdm.sv
// Directed bench for fir_sym_tdm: a DECIM=1 instance for the main checks and
// a DECIM=2 instance for the decimation check. Expected values are hand
// computed from the default coefficient set.
module tb_fir_sym_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       in_valid, in_ready, out_valid, coef_we, coef_err;
  logic [4:0] data_in, data_out;
  logic [3:0] coef_addr;
  logic [8:0] coef_wdata;

  logic       in_valid2, in_ready2, out_valid2, coef_we2, coef_err2;
  logic [4:0] data_in2, data_out2;
  logic [3:0] coef_addr2;
  logic [8:0] coef_wdata2;

  int total = 0;
  int bad   = 0;

  int imp_exp [20] = '{0, 0, 0, 0, 0, 0, -1, 0, 3, 6, 6, 3, 0, -1, 0, 0, 0, 0, 0, 0};

  fir_sym_tdm #(
    .DATA_W(5), .COEF_W(9), .N_TAPS(20), .N_MAC(2), .OUT_SHIFT(9), .DECIM(1)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .data_out(data_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err)
  );

  fir_sym_tdm #(
    .DATA_W(5), .COEF_W(9), .N_TAPS(20), .N_MAC(2), .OUT_SHIFT(9), .DECIM(2)
  ) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid2), .in_ready(in_ready2),
    .data_in(data_in2), .out_valid(out_valid2), .data_out(data_out2),
    .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_wdata(coef_wdata2),
    .coef_err(coef_err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; in_valid = 1'b0; coef_we = 1'b0; in_valid2 = 1'b0; coef_we2 = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic push(input logic [4:0] s, output logic [4:0] y, output int lat, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1'b1; data_in = s;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    y  = data_out;
    ok = out_valid;
  endtask

  task automatic load_all(input logic [8:0] v);
    for (int i = 0; i < 10; i++) begin
      coef_we = 1'b1; coef_addr = 4'(i); coef_wdata = v;
      tick();
    end
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (data_out !== 5'd0) begin bad++; $display("FAIL reset_data_out got=%0d exp=0", $signed(data_out)); end
    total++; if (coef_err !== 1'b0) begin bad++; $display("FAIL reset_coef_err got=%b exp=0", coef_err); end
  endtask

  task automatic test_impulse();
    logic [4:0] y, e;
    int lat;
    bit ok;
    for (int k = 0; k < 20; k++) begin
      push((k == 0) ? 5'd15 : 5'd0, y, lat, ok);
      e = imp_exp[k][4:0];
      total++;
      if (!ok || y !== e) begin
        bad++; $display("FAIL impulse[%0d] got=%0d valid=%b exp=%0d", k, $signed(y), ok, $signed(e));
      end
      if (k == 0) begin
        total++;
        if (lat != 5) begin bad++; $display("FAIL impulse_latency got=%0d exp=5", lat); end
      end
    end
  endtask

  task automatic test_dc();
    logic [4:0] y;
    int lat;
    bit ok;
    for (int k = 0; k < 40; k++) begin
      push(5'd15, y, lat, ok);
      if (k == 19 || k == 39) begin
        total++;
        if (!ok || y !== 5'd15) begin bad++; $display("FAIL dc_pos[%0d] got=%0d exp=15", k, $signed(y)); end
      end
    end
    for (int k = 0; k < 20; k++) push(5'h10, y, lat, ok);
    total++;
    if (!ok || y !== 5'h10) begin bad++; $display("FAIL dc_neg got=%0d exp=-16", $signed(y)); end
  endtask

  task automatic test_back_to_back();
    int acc_t [12];
    int out_t [12];
    logic [4:0] outv [12];
    logic [4:0] e;
    int n_acc, n_out, low, t;
    bit rdy, vld;
    do_reset();
    n_acc = 0; n_out = 0; low = 0; t = 0;
    in_valid = 1'b1; data_in = 5'd15;
    while (n_out < 12 && t < 300) begin
      rdy = in_ready; vld = in_valid;
      tick(); t++;
      if (rdy && vld) begin
        acc_t[n_acc] = t; n_acc++;
        if (n_acc == 12) in_valid = 1'b0; else data_in = 5'd0;
      end
      if (!in_ready) low++;
      if (out_valid) begin
        out_t[n_out] = t; outv[n_out] = data_out; n_out++;
      end
    end
    in_valid = 1'b0;
    total++; if (n_acc != 12) begin bad++; $display("FAIL b2b_accepts got=%0d exp=12", n_acc); end
    total++; if (n_out != 12) begin bad++; $display("FAIL b2b_outputs got=%0d exp=12", n_out); end
    total++; if (low != 60) begin bad++; $display("FAIL b2b_ready_low got=%0d exp=60", low); end
    for (int i = 0; i < n_out && i < n_acc; i++) begin
      e = imp_exp[i][4:0];
      total++;
      if (out_t[i] - acc_t[i] != 5) begin
        bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=5", i, out_t[i] - acc_t[i]);
      end
      total++;
      if (outv[i] !== e) begin
        bad++; $display("FAIL b2b_value[%0d] got=%0d exp=%0d", i, $signed(outv[i]), $signed(e));
      end
      if (i > 0) begin
        total++;
        if (acc_t[i] - acc_t[i-1] != 6) begin
          bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=6", i, acc_t[i] - acc_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [4:0] y;
    int lat;
    bit ok;
    load_all(9'h0FF);
    total++; if (coef_err !== 1'b0) begin bad++; $display("FAIL sat_load_err got=%b exp=0", coef_err); end
    for (int k = 0; k < 20; k++) push(5'd15, y, lat, ok);
    total++; if (!ok || y !== 5'd15) begin bad++; $display("FAIL sat_pos got=%0d exp=15", $signed(y)); end
    for (int k = 0; k < 20; k++) push(5'h10, y, lat, ok);
    total++; if (!ok || y !== 5'h10) begin bad++; $display("FAIL sat_neg got=%0d exp=-16", $signed(y)); end
  endtask

  task automatic test_coef_err();
    logic [4:0] y;
    int lat, n;
    bit ok;
    do_reset();
    for (int k = 0; k < 20; k++) push(5'd15, y, lat, ok);
    in_valid = 1'b1; data_in = 5'd15;
    tick();
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 4'd9; coef_wdata = 9'h100;
    tick();
    coef_we = 1'b0;
    total++; if (coef_err !== 1'b1) begin bad++; $display("FAIL busy_coef_err got=%b exp=1", coef_err); end
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    total++; if (!out_valid || data_out !== 5'd15) begin bad++; $display("FAIL busy_inflight got=%0d exp=15", $signed(data_out)); end
    push(5'd15, y, lat, ok);
    total++; if (!ok || y !== 5'd15) begin bad++; $display("FAIL busy_coef_kept got=%0d exp=15", $signed(y)); end
    total++; if (coef_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", coef_err); end
    do_reset();
    coef_we = 1'b1; coef_addr = 4'd10; coef_wdata = 9'h100;
    tick();
    coef_we = 1'b0;
    total++; if (coef_err !== 1'b1) begin bad++; $display("FAIL badaddr_coef_err got=%b exp=1", coef_err); end
    for (int k = 0; k < 20; k++) push(5'd15, y, lat, ok);
    total++; if (!ok || y !== 5'd15) begin bad++; $display("FAIL badaddr_coef_kept got=%0d exp=15", $signed(y)); end
  endtask

  task automatic test_reset_abort();
    logic [4:0] y;
    int lat, seen;
    bit ok;
    load_all(9'h0FF);
    for (int k = 0; k < 20; k++) push(5'd15, y, lat, ok);
    in_valid = 1'b1; data_in = 5'd15;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    resetn = 1'b0;
    #1;
    total++; if (data_out !== 5'd0) begin bad++; $display("FAIL abort_data_out got=%0d exp=0", $signed(data_out)); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
    seen = 0;
    repeat (2) begin tick(); if (out_valid) seen++; end
    resetn = 1'b1;
    repeat (8) begin tick(); if (out_valid) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_out_valid got=%0d pulses exp=0", seen); end
    for (int k = 0; k < 10; k++) begin
      push((k == 0) ? 5'd15 : 5'd0, y, lat, ok);
      if (k == 0 || k == 8 || k == 9) begin
        total++;
        if (!ok || y !== imp_exp[k][4:0]) begin
          bad++; $display("FAIL abort_impulse[%0d] got=%0d exp=%0d", k, $signed(y), imp_exp[k]);
        end
      end
    end
  endtask

  task automatic test_decim();
    int n, pulses, tot_p;
    do_reset();
    tot_p = 0;
    for (int i = 1; i <= 10; i++) begin
      n = 0;
      while (!in_ready2 && n < 20) begin tick(); n++; end
      in_valid2 = 1'b1; data_in2 = 5'(i);
      tick();
      in_valid2 = 1'b0;
      total++;
      if (in_ready2 !== ((i % 2) == 1)) begin
        bad++; $display("FAIL decim_ready[%0d] got=%b exp=%b", i, in_ready2, (i % 2) == 1);
      end
      pulses = 0;
      repeat (6) begin tick(); if (out_valid2) pulses++; end
      tot_p += pulses;
      total++;
      if (pulses != (((i % 2) == 0) ? 1 : 0)) begin
        bad++; $display("FAIL decim_pulse[%0d] got=%0d exp=%0d", i, pulses, ((i % 2) == 0) ? 1 : 0);
      end
    end
    total++; if (tot_p != 5) begin bad++; $display("FAIL decim_total got=%0d exp=5", tot_p); end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; data_in = '0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    in_valid2 = 1'b0; data_in2 = '0; coef_we2 = 1'b0; coef_addr2 = '0; coef_wdata2 = '0;
    test_reset();
    test_impulse();
    test_dc();
    test_back_to_back();
    test_saturation();
    test_reset_abort();
    test_coef_err();
    test_decim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
